// File: rtl/envelope_avg.sv
`default_nettype none
// ============================================================================
// Module   : envelope_avg
// Brief    : Windowed min/max envelope tracker. Averages each extremum over
//            2^AVG_LOG2 windows (block or sliding) and emits the midpoint.
// Revision : 1.0
// ============================================================================
module envelope_avg #(
    parameter int WIDTH         = 10,
    parameter int SEARCH_WINDOW = 64,
    parameter int AVG_LOG2      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_next,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_min_avg,
    output logic [WIDTH-1:0] o_max_avg,
    output logic [WIDTH-1:0] o_thresh,
    output logic             o_valid,
    output logic             o_locked
);

    localparam int c_DEPTH = 1 << AVG_LOG2;
    localparam int c_CNT_W = $clog2(SEARCH_WINDOW);
    localparam int c_WC_W  = AVG_LOG2 + 1;
    localparam int c_PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int c_ACC_W = WIDTH + AVG_LOG2;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SEARCH_WINDOW - 1);
    localparam logic [c_WC_W-1:0]  c_WC_LAST  = c_WC_W'(c_DEPTH - 1);
    localparam logic [c_WC_W-1:0]  c_WC_FULL  = c_WC_W'(c_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(c_DEPTH - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_WC_W-1:0]  r_wcnt;
    logic [c_PTR_W-1:0] r_ptr;
    logic [WIDTH-1:0]   r_run_min;
    logic [WIDTH-1:0]   r_run_max;
    logic [c_ACC_W-1:0] r_acc_min;
    logic [c_ACC_W-1:0] r_acc_max;
    logic               r_mode;
    logic [WIDTH-1:0]   r_buf_min [c_DEPTH];
    logic [WIDTH-1:0]   r_buf_max [c_DEPTH];

    logic [WIDTH-1:0]   w_win_min;
    logic [WIDTH-1:0]   w_win_max;
    logic               w_close;
    logic               w_flush;
    logic               w_full;
    logic               w_out_now;
    logic [WIDTH-1:0]   w_evict_min;
    logic [WIDTH-1:0]   w_evict_max;
    logic [c_ACC_W-1:0] w_sum_min;
    logic [c_ACC_W-1:0] w_sum_max;
    logic [WIDTH-1:0]   w_avg_min;
    logic [WIDTH-1:0]   w_avg_max;
    logic [WIDTH:0]     w_th_sum;
    logic [WIDTH-1:0]   w_thresh;

    assign w_win_min = (i_data < r_run_min) ? i_data : r_run_min;
    assign w_win_max = (i_data > r_run_max) ? i_data : r_run_max;
    assign w_close   = i_next && (r_cnt == c_CNT_LAST);
    assign w_flush   = (i_mode != r_mode);
    assign w_full    = (r_wcnt == c_WC_FULL);
    assign w_out_now = i_mode ? (r_wcnt >= c_WC_LAST) : (r_wcnt == c_WC_LAST);

    // Eviction only applies once the ring has wrapped; block mode never evicts.
    assign w_evict_min = (i_mode && w_full) ? r_buf_min[r_ptr] : '0;
    assign w_evict_max = (i_mode && w_full) ? r_buf_max[r_ptr] : '0;

    // The true sum always fits c_ACC_W bits, so modular add-then-subtract is exact.
    assign w_sum_min = r_acc_min + c_ACC_W'(w_win_min) - c_ACC_W'(w_evict_min);
    assign w_sum_max = r_acc_max + c_ACC_W'(w_win_max) - c_ACC_W'(w_evict_max);
    assign w_avg_min = WIDTH'(w_sum_min >> AVG_LOG2);
    assign w_avg_max = WIDTH'(w_sum_max >> AVG_LOG2);
    assign w_th_sum  = {1'b0, w_avg_min} + {1'b0, w_avg_max};
    assign w_thresh  = WIDTH'(w_th_sum >> 1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_wcnt    <= '0;
            r_ptr     <= '0;
            r_run_min <= '1;
            r_run_max <= '0;
            r_acc_min <= '0;
            r_acc_max <= '0;
            r_mode    <= i_mode;
            o_min_avg <= '0;
            o_max_avg <= '0;
            o_thresh  <= '0;
            o_valid   <= 1'b0;
            o_locked  <= 1'b0;
        end else if (w_flush) begin
            r_cnt     <= '0;
            r_wcnt    <= '0;
            r_ptr     <= '0;
            r_run_min <= '1;
            r_run_max <= '0;
            r_acc_min <= '0;
            r_acc_max <= '0;
            r_mode    <= i_mode;
            o_valid   <= 1'b0;
            o_locked  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_next) begin
                if (w_close) begin
                    r_cnt     <= '0;
                    r_run_min <= '1;
                    r_run_max <= '0;
                    if (w_out_now) begin
                        o_min_avg <= w_avg_min;
                        o_max_avg <= w_avg_max;
                        o_thresh  <= w_thresh;
                        o_valid   <= 1'b1;
                        o_locked  <= 1'b1;
                    end
                    if (i_mode) begin
                        r_acc_min <= w_sum_min;
                        r_acc_max <= w_sum_max;
                        r_ptr     <= (r_ptr == c_PTR_LAST) ? '0 : r_ptr + 1'b1;
                        if (!w_full) begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end else if (w_out_now) begin
                        r_acc_min <= '0;
                        r_acc_max <= '0;
                        r_wcnt    <= '0;
                    end else begin
                        r_acc_min <= w_sum_min;
                        r_acc_max <= w_sum_max;
                        r_wcnt    <= r_wcnt + 1'b1;
                    end
                end else begin
                    r_cnt     <= r_cnt + 1'b1;
                    r_run_min <= w_win_min;
                    r_run_max <= w_win_max;
                end
            end
        end
    end

    // History storage needs no reset: the fill count gates every read.
    always_ff @(posedge clk) begin
        if (reset && !w_flush && w_close && i_mode) begin
            r_buf_min[r_ptr] <= w_win_min;
            r_buf_max[r_ptr] <= w_win_max;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_envelope_avg.sv
`default_nettype none
// ============================================================================
// Module   : tb_envelope_avg
// Brief    : Vector table plus scoreboard bench for envelope_avg.
// Revision : 1.0
// ============================================================================
module tb_envelope_avg;

    localparam int W  = 10;
    localparam int SW = 4;
    localparam int AL = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         i_next = 1'b0;
    logic [W-1:0] i_data = '0;
    logic         i_mode = 1'b0;
    logic [W-1:0] o_min_avg;
    logic [W-1:0] o_max_avg;
    logic [W-1:0] o_thresh;
    logic         o_valid;
    logic         o_locked;

    envelope_avg #(
        .WIDTH        (W),
        .SEARCH_WINDOW(SW),
        .AVG_LOG2     (AL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_next   (i_next),
        .i_data   (i_data),
        .i_mode   (i_mode),
        .o_min_avg(o_min_avg),
        .o_max_avg(o_max_avg),
        .o_thresh (o_thresh),
        .o_valid  (o_valid),
        .o_locked (o_locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [W-1:0] data;
        int           gap;
        bit           mode;
        bit           last;
        logic [W-1:0] emin;
        logic [W-1:0] emax;
        logic [W-1:0] eth;
    } vec_t;

    typedef struct {
        logic [W-1:0] mn;
        logic [W-1:0] mx;
        logic [W-1:0] th;
        int           cyc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void add_vec(input logic [W-1:0] d, input int gap, input bit mode,
                                    input bit last, input logic [W-1:0] emin,
                                    input logic [W-1:0] emax, input logic [W-1:0] eth);
        vec_t v;
        v.data = d; v.gap = gap; v.mode = mode; v.last = last;
        v.emin = emin; v.emax = emax; v.eth = eth;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        i_mode = v.mode;
        i_next = 1'b1;
        i_data = v.data;
        if (v.last) begin
            e.mn = v.emin; e.mx = v.emax; e.th = v.eth; e.cyc = cyc + 1;
            sb.push_back(e);
        end
        repeat (v.gap) begin
            @(negedge clk);
            i_next = 1'b0;
        end
    endtask

    task automatic apply_range(input int lo, input int hi);
        for (int k = lo; k < hi; k++) apply(vecs[k]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_next = 1'b0;
        end
    endtask

    // Scoreboard consumer: every o_valid must match the next expected update.
    always @(negedge clk) begin
        if (reset && o_valid) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got o_valid=1, required 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("min_avg", o_min_avg, e.mn);
                chk("max_avg", o_max_avg, e.mx);
                chk("thresh", o_thresh, e.th);
                chk("locked_on_valid", o_locked, 1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Phase A [0,16): block windows min 10w, max 100w -> 25/250/137
        for (int w = 1; w <= 4; w++) begin
            add_vec(W'(10*w + 1), 0, 1'b0, 1'b0, '0, '0, '0);
            add_vec(W'(100*w),    0, 1'b0, 1'b0, '0, '0, '0);
            add_vec(W'(10*w),     0, 1'b0, 1'b0, '0, '0, '0);
            add_vec(W'(100*w - 1), 0, 1'b0, (w == 4), 10'd25, 10'd250, 10'd137);
        end
        // Phase B [16,32): max on first sample, min on closing sample
        for (int w = 1; w <= 4; w++) begin
            add_vec(10'd1023, 0, 1'b0, 1'b0, '0, '0, '0);
            add_vec(10'd60,   0, 1'b0, 1'b0, '0, '0, '0);
            add_vec(10'd70,   0, 1'b0, 1'b0, '0, '0, '0);
            add_vec(10'd5,    0, 1'b0, (w == 4), 10'd5, 10'd1023, 10'd514);
        end
        // Phase C [32,48): phase A data strobed every 3rd cycle
        for (int k = 0; k < 16; k++) begin
            vec_t v;
            v = vecs[k];
            v.gap = 2;
            vecs.push_back(v);
        end
        // Phase D [48,72): sliding, window minima 8,8,8,8,16,16, max 200
        for (int w = 1; w <= 6; w++) begin
            logic [W-1:0] m;
            logic [W-1:0] em;
            logic [W-1:0] et;
            m  = (w <= 4) ? 10'd8 : 10'd16;
            em = (w == 4) ? 10'd8 : (w == 5) ? 10'd10 : 10'd12;
            et = (w == 4) ? 10'd104 : (w == 5) ? 10'd105 : 10'd106;
            add_vec(10'd200, 0, 1'b1, 1'b0, '0, '0, '0);
            add_vec(m,       0, 1'b1, 1'b0, '0, '0, '0);
            add_vec(10'd100, 0, 1'b1, 1'b0, '0, '0, '0);
            add_vec(10'd150, 0, 1'b1, (w >= 4), em, 10'd200, et);
        end

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk("rst_min_avg", o_min_avg, 0);
        chk("rst_max_avg", o_max_avg, 0);
        chk("rst_thresh", o_thresh, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_locked", o_locked, 0);

        // Block averaging, closing-sample extremum, gapped strobes
        apply_range(0, 16);
        idle(3);
        chk("A_locked", o_locked, 1);
        chk("A_drain", sb.size(), 0);
        apply_range(16, 32);
        idle(3);
        chk("B_drain", sb.size(), 0);
        apply_range(32, 48);
        idle(3);
        chk("C_drain", sb.size(), 0);
        chk("C_hold_min", o_min_avg, 25);

        // Reset mid-window, then a full fresh average
        apply_range(0, 10);
        @(negedge clk);
        reset = 1'b0;
        i_next = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_min_avg", o_min_avg, 0);
        chk("midrst_max_avg", o_max_avg, 0);
        chk("midrst_thresh", o_thresh, 0);
        chk("midrst_locked", o_locked, 0);
        apply_range(0, 16);
        idle(3);
        chk("R_drain", sb.size(), 0);

        // Mode toggle on sample 9 while locked: sample discarded, outputs held
        apply_range(0, 8);
        @(negedge clk);
        i_mode = 1'b1;
        i_next = 1'b1;
        i_data = 10'd0;
        @(negedge clk);
        i_next = 1'b0;
        chk("flush_locked", o_locked, 0);
        chk("flush_valid", o_valid, 0);
        chk("flush_hold_min", o_min_avg, 25);
        chk("flush_hold_max", o_max_avg, 250);
        chk("flush_hold_thresh", o_thresh, 137);

        // Sliding mode after the flush
        apply_range(48, 60);
        idle(2);
        chk("D_not_locked", o_locked, 0);
        apply_range(60, 72);
        idle(3);
        chk("D_locked", o_locked, 1);
        chk("D_drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
